// File: rtl/red_pitaya_bus_pkg.sv
// Shared definitions for the sub-module register bus.
// Holds the default bus widths, the initiator FSM state encoding and the
// read value returned on a timed-out access. Responder blocks import this too.
package red_pitaya_bus_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;

   // Initiator FSM state encoding
   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
   localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
   localparam logic [1:0] ST_RESP_ENC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_ISSUE = ST_ISSUE_ENC,
      ST_WAIT  = ST_WAIT_ENC,
      ST_RESP  = ST_RESP_ENC
   } bus_state_t;

   // Read data reported when an access times out
   localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/red_pitaya_bus_initiator.sv
// Register bus initiator.
// Takes one transaction at a time from a valid/ready request port, issues it
// on the bus as a single-cycle wen/ren strobe, waits for ack (with optional
// timeout) and returns read data plus an error flag on a valid/ready
// response port.
// Ports:
//   clk_i, rstn_i                     clock, async active-low reset
//   req_valid_i/req_ready_o           request handshake
//   req_write_i, req_addr_i,
//   req_wdata_i                       request payload
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o, rsp_err_o            response payload (err = timed out)
//   busy_o                            FSM not idle
//   addr, wen, ren, wdata             bus outputs (registered)
//   ack, rdata                        bus inputs
module red_pitaya_bus_initiator
   import red_pitaya_bus_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 8,
   parameter int TOBITS  = 8
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_write_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          busy_o,
   output logic [AW-1:0] addr,
   output logic          wen,
   output logic          ren,
   output logic [DW-1:0] wdata,
   input  logic          ack,
   input  logic [DW-1:0] rdata
);

   // Last counter value before giving up; unused when TIMEOUT == 0
   localparam logic [TOBITS-1:0] TO_LAST = TOBITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   bus_state_t        r_state;
   bus_state_t        w_state_nxt;
   logic [TOBITS-1:0] r_cnt;
   logic              r_write;
   logic              w_timeout;

   assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);
   assign req_ready_o = (r_state == ST_IDLE);
   assign busy_o      = (r_state != ST_IDLE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (req_valid_i)        w_state_nxt = ST_ISSUE;
         // A combinational responder may ack in the strobe cycle itself
         ST_ISSUE: w_state_nxt = ack ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (ack || w_timeout)   w_state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready_i)        w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Bus outputs, timeout counter and response register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         addr        <= '0;
         wdata       <= '0;
         wen         <= 1'b0;
         ren         <= 1'b0;
         r_write     <= 1'b0;
         r_cnt       <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  addr    <= req_addr_i;
                  if (req_write_i) wdata <= req_wdata_i;
                  wen     <= req_write_i;
                  ren     <= ~req_write_i;
                  r_write <= req_write_i;
               end
            end
            ST_ISSUE: begin
               wen   <= 1'b0;
               ren   <= 1'b0;
               r_cnt <= '0;
               if (ack) begin
                  rsp_rdata_o <= r_write ? '0 : rdata;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
               end
            end
            ST_WAIT: begin
               // ack has priority over a timeout in the same cycle
               if (ack) begin
                  rsp_rdata_o <= r_write ? '0 : rdata;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
               end else if (w_timeout) begin
                  rsp_rdata_o <= DW'(ERR_RDATA);
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) rsp_valid_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
